core_sequencer: RTL and testbench

- Multi-cycle fetch/decode/execute controller for the 4-bit microcore.
- Owns the program counter and requests instruction bytes from program memory.
- Pulses the instruction register enable, then decodes the latched fields (mnm, wr_addr_mnm, rd_addr_wr_data).
- Drives register-file write, ALU-select and PC-load controls for one instruction at a time.

---
 rtl/core_pkg.sv | 39 +++
 rtl/pc_counter.sv | 31 +++
 rtl/core_sequencer.sv | 131 +++++++++++++
 tb/tb_core_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared opcodes, sub-ops and state encodings for the microcore sequencer.
// Optional single-step support is enabled with CORE_SEQUENCER_STEP_EN.
package core_pkg;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_SYS = 2'b11;

  localparam logic [1:0] SYS_NOP  = 2'b00;
  localparam logic [1:0] SYS_OUT  = 2'b01;
  localparam logic [1:0] SYS_HALT = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT,
    ST_PAUSE
  } state_t;

  // What EXEC does to the PC: advance, load a jump target, or freeze on HALT.
  typedef enum logic [1:0] {
    EX_STEP,
    EX_JMP,
    EX_HALT
  } exec_t;

  function automatic exec_t classify(input logic [1:0] op, input logic [1:0] sub);
    exec_t kind;
    kind = EX_STEP;
    if (op == OP_JMP) kind = EX_JMP;
    else if (op == OP_SYS && sub == SYS_HALT) kind = EX_HALT;
    return kind;
  endfunction

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with load, wrapping increment and async reset to START_PC.
// Load has priority over increment.
module pc_counter #(
  parameter int PC_W     = 6,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            inc_i,
  input  logic [PC_W-1:0] load_val_i,
  output logic [PC_W-1:0] pc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) pc_d = load_val_i;
    else if (inc_i) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= PC_W'(START_PC);
    else     pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - fetch/latch/decode/execute controller for the 4-bit microcore.
// Define CORE_SEQUENCER_STEP_EN to add the step input and the PAUSE state.
module core_sequencer
  import core_pkg::*;
#(
  parameter int PC_W     = 6,
  parameter int START_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
`ifdef CORE_SEQUENCER_STEP_EN
  input  logic            step,
`endif
  output logic            mem_rd,
  output logic [PC_W-1:0] pc_out,
  input  logic            mem_valid,
  output logic            ir_ena,
  input  logic [1:0]      mnm,
  input  logic [1:0]      wr_addr_mnm,
  input  logic [3:0]      rd_addr_wr_data,
  output logic            rf_we,
  output logic [1:0]      rf_waddr,
  output logic [1:0]      rf_raddr,
  output logic            rf_wsel,
  output logic            out_valid,
  output logic            busy,
  output logic            halted
);

  state_t state_q, state_d;
  exec_t  exec_q;
  logic   mem_rd_q, ir_ena_q, rf_we_q, rf_wsel_q, out_valid_q, busy_q, halted_q;
  logic [1:0] rf_waddr_q, rf_raddr_q;
  logic   pc_load, pc_inc;
  logic [PC_W-1:0] jmp_target;

`ifdef CORE_SEQUENCER_STEP_EN
  logic step_prev_q;
  logic step_rise;
  assign step_rise = step & ~step_prev_q;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (mem_valid) state_d = ST_LATCH;
      ST_LATCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (exec_q == EX_HALT) state_d = ST_HALT;
`ifdef CORE_SEQUENCER_STEP_EN
        else state_d = ST_PAUSE;
`else
        else state_d = ST_FETCH;
`endif
      end
      ST_HALT:   state_d = ST_HALT;
`ifdef CORE_SEQUENCER_STEP_EN
      ST_PAUSE:  if (step_rise) state_d = ST_FETCH;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  // IR fields stay stable through EXEC, so the jump target is taken directly from them.
  assign jmp_target = PC_W'({wr_addr_mnm, rd_addr_wr_data});
  assign pc_load    = (state_q == ST_EXEC) && (exec_q == EX_JMP);
  assign pc_inc     = (state_q == ST_EXEC) && (exec_q == EX_STEP);

  pc_counter #(
    .PC_W     (PC_W),
    .START_PC (START_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_i     (pc_load),
    .inc_i      (pc_inc),
    .load_val_i (jmp_target),
    .pc_o       (pc_out)
  );

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      exec_q      <= EX_STEP;
      mem_rd_q    <= 1'b0;
      ir_ena_q    <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= 2'b00;
      rf_raddr_q  <= 2'b00;
      rf_wsel_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
`ifdef CORE_SEQUENCER_STEP_EN
      step_prev_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_rd_q    <= (state_d == ST_FETCH);
      ir_ena_q    <= (state_d == ST_LATCH);
      busy_q      <= !(state_d inside {ST_IDLE, ST_HALT, ST_PAUSE});
      halted_q    <= (state_d == ST_HALT);
      rf_we_q     <= (state_q == ST_DECODE) && (mnm == OP_LDI || mnm == OP_ADD);
      out_valid_q <= (state_q == ST_DECODE) && (mnm == OP_SYS) && (wr_addr_mnm == SYS_OUT);
      if (state_q == ST_DECODE) begin
        exec_q     <= classify(mnm, wr_addr_mnm);
        rf_waddr_q <= wr_addr_mnm;
        rf_raddr_q <= rd_addr_wr_data[1:0];
        rf_wsel_q  <= (mnm == OP_ADD);
      end
`ifdef CORE_SEQUENCER_STEP_EN
      step_prev_q <= step;
`endif
    end
  end

  assign mem_rd    = mem_rd_q;
  assign ir_ena    = ir_ena_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_raddr  = rf_raddr_q;
  assign rf_wsel   = rf_wsel_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - directed self-checking bench for core_sequencer with an event scoreboard.
// Step-mode scenarios run only when CORE_SEQUENCER_STEP_EN is defined.
module tb_core_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       mem_valid = 1'b0;
  logic       mem_rd, ir_ena, rf_we, rf_wsel, out_valid, busy, halted;
  logic [5:0] pc_out;
  logic [1:0] rf_waddr, rf_raddr;
  logic [7:0] ir = 8'hC0;
  logic [7:0] mem [64];
  logic [1:0] mnm, wr_addr_mnm;
  logic [3:0] rd_addr_wr_data;
`ifdef CORE_SEQUENCER_STEP_EN
  logic       step = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_out;
    logic [1:0] waddr;
    logic       wsel;
    logic [1:0] raddr;
  } ev_t;
  ev_t sb[$];

  always #5 clk = ~clk;

  assign mnm             = ir[7:6];
  assign wr_addr_mnm     = ir[5:4];
  assign rd_addr_wr_data = ir[3:0];

  // Instruction register model: loads the addressed byte when ir_ena is high.
  always @(posedge clk) if (ir_ena) ir <= mem[pc_out];

  core_sequencer #(.PC_W(6), .START_PC(0)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
`ifdef CORE_SEQUENCER_STEP_EN
    .step            (step),
`endif
    .mem_rd          (mem_rd),
    .pc_out          (pc_out),
    .mem_valid       (mem_valid),
    .ir_ena          (ir_ena),
    .mnm             (mnm),
    .wr_addr_mnm     (wr_addr_mnm),
    .rd_addr_wr_data (rd_addr_wr_data),
    .rf_we           (rf_we),
    .rf_waddr        (rf_waddr),
    .rf_raddr        (rf_raddr),
    .rf_wsel         (rf_wsel),
    .out_valid       (out_valid),
    .busy            (busy),
    .halted          (halted)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 8'hC0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    mem_valid = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (halted) break;
      tick(1);
    end
    check("halt_reached", halted, 1);
  endtask

  // Scoreboard monitor: every write or OUT strobe must match the next expected event.
  always @(negedge clk) begin
    if (!rst && (rf_we || out_valid)) begin
      ev_t obs_ev, exp_ev;
      obs_ev = out_valid ? ev_t'{1'b1, 2'b00, 1'b0, 2'b00} : ev_t'{1'b0, rf_waddr, rf_wsel, rf_raddr};
      if (sb.size() == 0) begin
        check("sb_unexpected_event", obs_ev, 7'h7f ^ obs_ev);
      end else begin
        exp_ev = sb.pop_front();
        check("sb_event", obs_ev, exp_ev);
      end
    end
  end

  initial begin
    clear_mem();
    do_reset();
    check("rst_mem_rd", mem_rd, 0);
    check("rst_ir_ena", ir_ena, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc_out, 0);
    check("rst_ctrl", {rf_we, out_valid, rf_waddr, rf_raddr, rf_wsel}, 0);

    // Reset mid-FETCH takes effect without a clock edge.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("fetch_mem_rd", mem_rd, 1);
    check("fetch_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_mem_rd", mem_rd, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_pc", pc_out, 0);
    tick(1);
    rst = 1'b0;
    tick(1);

`ifndef CORE_SEQUENCER_STEP_EN
    // LDI r2, 0xA then HALT with memory always ready.
    clear_mem();
    mem[0] = 8'h2A;
    mem[1] = 8'hE0;
    do_reset();
    mem_valid = 1'b1;
    sb.push_back(ev_t'{1'b0, 2'd2, 1'b0, 2'd2});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("c1_mem_rd", mem_rd, 1);
    check("c1_ir_ena", ir_ena, 0);
    tick(1);
    check("c2_ir_ena", ir_ena, 1);
    tick(1);
    check("c3_ir_ena", ir_ena, 0);
    tick(1);
    check("c4_rf_we", rf_we, 1);
    check("c4_rf_waddr", rf_waddr, 2);
    check("c4_rf_wsel", rf_wsel, 0);
    check("c4_pc", pc_out, 0);
    tick(1);
    check("c5_pc", pc_out, 1);
    check("c5_rf_we", rf_we, 0);
    check("c5_mem_rd", mem_rd, 1);
    tick(4);
    check("halt_halted", halted, 1);
    check("halt_busy", busy, 0);
    check("halt_pc", pc_out, 1);
    start = 1'b1;
    tick(3);
    start = 1'b0;
    check("halt_sticky", halted, 1);
    check("halt_no_fetch", mem_rd, 0);
    check("halt_pc_hold", pc_out, 1);

    // ADD r1, r0 with five wait cycles in FETCH.
    clear_mem();
    mem[0] = 8'h50;
    mem[1] = 8'hE0;
    do_reset();
    sb.push_back(ev_t'{1'b0, 2'd1, 1'b1, 2'd0});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("wait_mem_rd", mem_rd, 1);
      check("wait_pc", pc_out, 0);
      check("wait_ir_ena", ir_ena, 0);
    end
    mem_valid = 1'b1;
    tick(1);
    check("wait_latch", ir_ena, 1);
    mem_valid = 1'b0;
    tick(3);
    check("wait_next_pc", pc_out, 1);
    mem_valid = 1'b1;
    wait_halted(20);

    // JMP 0x1F, JMP 0x3F, OUT at 0x3F, then PC wraps to 0.
    clear_mem();
    mem[0]    = 8'h9F;
    mem[6'h1F] = 8'hBF;
    mem[6'h3F] = 8'hD0;
    do_reset();
    mem_valid = 1'b1;
    sb.push_back(ev_t'{1'b1, 2'b00, 1'b0, 2'b00});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("jmp_pc_1f", pc_out, 6'h1F);
    tick(4);
    check("jmp_pc_3f", pc_out, 6'h3F);
    tick(3);
    check("out_valid_exec", out_valid, 1);
    tick(1);
    check("out_valid_one_cycle", out_valid, 0);
    check("pc_wrap", pc_out, 0);

    // JMP to its own address loops.
    clear_mem();
    mem[0] = 8'h80;
    do_reset();
    mem_valid = 1'b1;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    check("self_jmp_pc", pc_out, 0);
    check("self_jmp_fetch", mem_rd, 1);
`else
    // OUT, then PAUSE until a step edge releases exactly one instruction.
    clear_mem();
    mem[0] = 8'hD0;
    mem[1] = 8'h2A;
    do_reset();
    mem_valid = 1'b1;
    sb.push_back(ev_t'{1'b1, 2'b00, 1'b0, 2'b00});
    sb.push_back(ev_t'{1'b0, 2'd2, 1'b0, 2'd2});
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    check("step_out_valid", out_valid, 1);
    tick(1);
    check("pause_busy", busy, 0);
    check("pause_mem_rd", mem_rd, 0);
    check("pause_pc", pc_out, 1);
    tick(3);
    check("pause_hold", mem_rd, 0);
    step = 1'b1;
    tick(1);
    check("step_fetch", mem_rd, 1);
    tick(3);
    check("step_exec_we", rf_we, 1);
    tick(5);
    check("step_held_pause", mem_rd, 0);
    check("step_held_pc", pc_out, 2);
    step = 1'b0;
`endif

    tick(2);
    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
